// File: rtl/cpu_pkg.sv
// Shared widths, FSM state type and branch-offset helper for the PC sequencer.
package cpu_pkg;

    localparam int PC_WIDTH     = 32;
    localparam int INSTR_WIDTH  = 32;
    localparam int COUNT_WIDTH  = 16;
    localparam int PC_STEP      = 4;
    localparam int OFFSET_MSB   = 23;
    localparam int OFFSET_LSB   = 16;
    localparam int OFFSET_WIDTH = OFFSET_MSB - OFFSET_LSB + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH     = 2'd1,
        EXEC      = 2'd2,
        MEM_STALL = 2'd3
    } state_t;

    // Offsets count words, so the byte displacement is the sign-extended field times four.
    function automatic logic [PC_WIDTH-1:0] word_offset(input logic [OFFSET_WIDTH-1:0] offset);
        return {{(PC_WIDTH-OFFSET_WIDTH-2){offset[OFFSET_WIDTH-1]}}, offset, 2'b00};
    endfunction

endpackage

// File: rtl/pc_target_adder.sv
// Combinational next-PC: sequential step, plus the word displacement when taken.
module pc_target_adder
    import cpu_pkg::*;
(
    input  logic [PC_WIDTH-1:0]     pc,
    input  logic [OFFSET_WIDTH-1:0] offset,
    input  logic                    taken,
    output logic [PC_WIDTH-1:0]     next_pc
);

    logic [PC_WIDTH-1:0] seq_pc;
    logic [PC_WIDTH-1:0] branch_disp;

    assign seq_pc      = pc + PC_WIDTH'(PC_STEP);
    assign branch_disp = taken ? word_offset(offset) : '0;
    assign next_pc     = seq_pc + branch_disp;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer with instruction and data memory wait handling.
// Define PC_SEQ_BNE_EN to add the BNE input and branch-if-not-zero support.
module pc_sequencer
    import cpu_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [INSTR_WIDTH-1:0] INSTRUCTION,
    input  logic                   IMEM_BUSYWAIT,
    input  logic                   DMEM_BUSYWAIT,
    input  logic                   JUMP,
    input  logic                   BRANCH,
    input  logic                   ZERO,
`ifdef PC_SEQ_BNE_EN
    input  logic                   BNE,
`endif
    output logic                   IMEM_READ,
    output logic [PC_WIDTH-1:0]    PC,
    output logic [INSTR_WIDTH-1:0] INSTR_OUT,
    output logic                   INSTR_VALID,
    output logic                   STALL,
    output logic [COUNT_WIDTH-1:0] INSTR_COUNT
);

    state_t                 state_reg;
    logic [PC_WIDTH-1:0]    pc_reg;
    logic [INSTR_WIDTH-1:0] instr_reg;
    logic [COUNT_WIDTH-1:0] count_reg;
    logic                   imem_read_reg;
    logic                   instr_valid_reg;
    logic                   stall_reg;

    logic                   taken;
    logic [PC_WIDTH-1:0]    pc_next;

    // Every taken form shares one target, so JUMP > BRANCH > BNE priority needs no mux.
`ifdef PC_SEQ_BNE_EN
    assign taken = JUMP | (BRANCH & ZERO) | (BNE & ~ZERO);
`else
    assign taken = JUMP | (BRANCH & ZERO);
`endif

    pc_target_adder u_target (
        .pc      (pc_reg),
        .offset  (instr_reg[OFFSET_MSB:OFFSET_LSB]),
        .taken   (taken),
        .next_pc (pc_next)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg       <= IDLE;
            pc_reg          <= '0;
            instr_reg       <= '0;
            count_reg       <= '0;
            imem_read_reg   <= 1'b0;
            instr_valid_reg <= 1'b0;
            stall_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg     <= FETCH;
                    imem_read_reg <= 1'b1;
                end
                FETCH: begin
                    if (!IMEM_BUSYWAIT) begin
                        instr_reg       <= INSTRUCTION;
                        state_reg       <= EXEC;
                        imem_read_reg   <= 1'b0;
                        instr_valid_reg <= 1'b1;
                    end
                end
                EXEC: begin
                    instr_valid_reg <= 1'b0;
                    if (DMEM_BUSYWAIT) begin
                        state_reg <= MEM_STALL;
                        stall_reg <= 1'b1;
                    end else begin
                        pc_reg        <= pc_next;
                        count_reg     <= count_reg + COUNT_WIDTH'(1);
                        state_reg     <= FETCH;
                        imem_read_reg <= 1'b1;
                    end
                end
                MEM_STALL: begin
                    if (!DMEM_BUSYWAIT) begin
                        stall_reg     <= 1'b0;
                        pc_reg        <= pc_next;
                        count_reg     <= count_reg + COUNT_WIDTH'(1);
                        state_reg     <= FETCH;
                        imem_read_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg       <= IDLE;
                    imem_read_reg   <= 1'b0;
                    instr_valid_reg <= 1'b0;
                    stall_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign IMEM_READ   = imem_read_reg;
    assign PC          = pc_reg;
    assign INSTR_OUT   = instr_reg;
    assign INSTR_VALID = instr_valid_reg;
    assign STALL       = stall_reg;
    assign INSTR_COUNT = count_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer against an arithmetic next-PC / retire-count model.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] INSTRUCTION = '0;
    logic        IMEM_BUSYWAIT = 1'b0;
    logic        DMEM_BUSYWAIT = 1'b0;
    logic        JUMP = 1'b0;
    logic        BRANCH = 1'b0;
    logic        ZERO = 1'b0;
`ifdef PC_SEQ_BNE_EN
    logic        BNE = 1'b0;
`endif
    logic        IMEM_READ;
    logic [31:0] PC;
    logic [31:0] INSTR_OUT;
    logic        INSTR_VALID;
    logic        STALL;
    logic [15:0] INSTR_COUNT;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_pc = '0;
    logic [15:0] m_count = '0;

    pc_sequencer dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .INSTRUCTION   (INSTRUCTION),
        .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
        .DMEM_BUSYWAIT (DMEM_BUSYWAIT),
        .JUMP          (JUMP),
        .BRANCH        (BRANCH),
        .ZERO          (ZERO),
`ifdef PC_SEQ_BNE_EN
        .BNE           (BNE),
`endif
        .IMEM_READ     (IMEM_READ),
        .PC            (PC),
        .INSTR_OUT     (INSTR_OUT),
        .INSTR_VALID   (INSTR_VALID),
        .STALL         (STALL),
        .INSTR_COUNT   (INSTR_COUNT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference: next PC from plain signed integer arithmetic on the offset field.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] word,
                                               input logic j, input logic b, input logic z, input logic n);
        logic [7:0] field;
        int         off;
        bit         tk;
        field = word[23:16];
        off   = int'($signed(field));
        tk    = j || (b && z) || (n && !z);
        return tk ? pc + 32'd4 + 32'(off * 4) : pc + 32'd4;
    endfunction

    function automatic logic [31:0] mk_word(input logic [7:0] off);
        logic [31:0] w;
        w = $urandom;
        w[23:16] = off;
        return w;
    endfunction

    // Starts and ends at a falling edge with the DUT in FETCH.
    task automatic run_instr(input logic [31:0] word, input int ibusy, input int dbusy,
                             input logic j, input logic b, input logic z, input logic n);
        logic [31:0] exp_next;
        exp_next = model_next(m_pc, word, j, b, z, n);
        checks++; if (IMEM_READ !== 1'b1) begin failures++; $display("FAIL fetch_req: got %b expected 1", IMEM_READ); end
        checks++; if (PC !== m_pc) begin failures++; $display("FAIL fetch_pc: got %h expected %h", PC, m_pc); end
        for (int k = 0; k <= ibusy; k++) begin
            if (k > 0) begin
                @(negedge CLK);
                checks++; if (IMEM_READ !== 1'b1 || PC !== m_pc || INSTR_VALID !== 1'b0) begin
                    failures++; $display("FAIL imem_wait: got read=%b pc=%h valid=%b expected 1 %h 0", IMEM_READ, PC, INSTR_VALID, m_pc);
                end
            end
            IMEM_BUSYWAIT = (k < ibusy);
            INSTRUCTION   = (k < ibusy) ? 32'($urandom) : word;
            DMEM_BUSYWAIT = 1'($urandom);
        end
        @(negedge CLK);
        checks++; if (INSTR_VALID !== 1'b1 || IMEM_READ !== 1'b0 || STALL !== 1'b0) begin
            failures++; $display("FAIL exec_flags: got valid=%b read=%b stall=%b expected 1 0 0", INSTR_VALID, IMEM_READ, STALL);
        end
        checks++; if (INSTR_OUT !== word) begin failures++; $display("FAIL instr_out: got %h expected %h", INSTR_OUT, word); end
        checks++; if (PC !== m_pc) begin failures++; $display("FAIL exec_pc: got %h expected %h", PC, m_pc); end
        JUMP = j; BRANCH = b; ZERO = z;
`ifdef PC_SEQ_BNE_EN
        BNE = n;
`endif
        DMEM_BUSYWAIT = (dbusy > 0);
        IMEM_BUSYWAIT = 1'($urandom);
        for (int k = 0; k < dbusy; k++) begin
            @(negedge CLK);
            checks++; if (STALL !== 1'b1 || INSTR_VALID !== 1'b0 || IMEM_READ !== 1'b0 || PC !== m_pc) begin
                failures++; $display("FAIL dmem_stall: got stall=%b valid=%b read=%b pc=%h expected 1 0 0 %h", STALL, INSTR_VALID, IMEM_READ, PC, m_pc);
            end
            DMEM_BUSYWAIT = (k < dbusy - 1);
            IMEM_BUSYWAIT = 1'($urandom);
        end
        @(negedge CLK);
        m_pc    = exp_next;
        m_count = m_count + 16'd1;
        checks++; if (PC !== m_pc) begin failures++; $display("FAIL next_pc: got %h expected %h", PC, m_pc); end
        checks++; if (INSTR_COUNT !== m_count) begin failures++; $display("FAIL count: got %h expected %h", INSTR_COUNT, m_count); end
        checks++; if (STALL !== 1'b0 || INSTR_VALID !== 1'b0) begin
            failures++; $display("FAIL retire_flags: got stall=%b valid=%b expected 0 0", STALL, INSTR_VALID);
        end
        IMEM_BUSYWAIT = 1'b0; DMEM_BUSYWAIT = 1'($urandom);
        JUMP = 1'b0; BRANCH = 1'b0; ZERO = 1'b0;
`ifdef PC_SEQ_BNE_EN
        BNE = 1'b0;
`endif
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1; IMEM_BUSYWAIT = 1'b0; DMEM_BUSYWAIT = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        m_pc = '0; m_count = '0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        checks++; if ({IMEM_READ, INSTR_VALID, STALL} !== 3'b000 || PC !== 32'd0 || INSTR_OUT !== 32'd0 || INSTR_COUNT !== 16'd0) begin
            failures++; $display("FAIL reset_state: got read=%b valid=%b stall=%b pc=%h instr=%h cnt=%h expected all zero",
                                 IMEM_READ, INSTR_VALID, STALL, PC, INSTR_OUT, INSTR_COUNT);
        end
        RESET = 1'b0;
        #1;
        checks++; if (IMEM_READ !== 1'b0) begin failures++; $display("FAIL idle_read: got %b expected 0", IMEM_READ); end
        @(negedge CLK);
        checks++; if (IMEM_READ !== 1'b1 || PC !== 32'd0) begin
            failures++; $display("FAIL first_fetch: got read=%b pc=%h expected 1 00000000", IMEM_READ, PC);
        end
        m_pc = '0; m_count = '0;
    endtask

    task automatic test_straight_line();
        for (int i = 0; i < 3; i++) run_instr(mk_word(8'h00), 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (PC !== 32'd12 || INSTR_COUNT !== 16'd3) begin
            failures++; $display("FAIL straight_line: got pc=%h cnt=%0d expected 0000000c 3", PC, INSTR_COUNT);
        end
    endtask

    task automatic test_imem_wait();
        do_reset();
        run_instr(mk_word(8'h00), 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(mk_word(8'h00), 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(mk_word(8'h00), 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_branch();
        do_reset();
        for (int i = 0; i < 4; i++) run_instr(mk_word(8'h00), 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(mk_word(8'hFE), 0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (PC !== 32'h0C) begin failures++; $display("FAIL beq_taken: got %h expected 0000000c", PC); end
        run_instr(mk_word(8'h00), 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(mk_word(8'hFE), 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (PC !== 32'h14) begin failures++; $display("FAIL beq_not_taken: got %h expected 00000014", PC); end
    endtask

    task automatic test_priority();
        for (int i = 0; i < 3; i++) run_instr(mk_word(8'h00), 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(mk_word(8'h02), 0, 0, 1'b1, 1'b1, 1'($urandom), 1'b0);
        checks++; if (PC !== 32'h2C) begin failures++; $display("FAIL jump_priority: got %h expected 0000002c", PC); end
    endtask

    task automatic test_data_stall();
        run_instr(mk_word(8'h00), 0, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_stall();
        INSTRUCTION = mk_word(8'h00);
        IMEM_BUSYWAIT = 1'b0; DMEM_BUSYWAIT = 1'b0;
        @(negedge CLK);
        DMEM_BUSYWAIT = 1'b1;
        @(negedge CLK);
        checks++; if (STALL !== 1'b1) begin failures++; $display("FAIL pre_reset_stall: got %b expected 1", STALL); end
        @(posedge CLK);
        #2 RESET = 1'b1;
        #1;
        checks++; if ({IMEM_READ, INSTR_VALID, STALL} !== 3'b000 || PC !== 32'd0 || INSTR_OUT !== 32'd0 || INSTR_COUNT !== 16'd0) begin
            failures++; $display("FAIL async_reset: got read=%b valid=%b stall=%b pc=%h instr=%h cnt=%h expected all zero",
                                 IMEM_READ, INSTR_VALID, STALL, PC, INSTR_OUT, INSTR_COUNT);
        end
        @(negedge CLK);
        RESET = 1'b0; DMEM_BUSYWAIT = 1'b0;
        @(negedge CLK);
        m_pc = '0; m_count = '0;
        checks++; if (IMEM_READ !== 1'b1 || PC !== 32'd0) begin
            failures++; $display("FAIL refetch_after_reset: got read=%b pc=%h expected 1 00000000", IMEM_READ, PC);
        end
    endtask

    task automatic test_count_wrap();
        force dut.count_reg = 16'hFFFE;
        #1;
        release dut.count_reg;
        m_count = 16'hFFFE;
        for (int i = 0; i < 3; i++) run_instr(mk_word(8'($urandom)), 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (INSTR_COUNT !== 16'h0001) begin failures++; $display("FAIL count_wrap: got %h expected 0001", INSTR_COUNT); end
    endtask

    task automatic test_random();
        logic n;
        for (int i = 0; i < 30; i++) begin
            n = 1'b0;
`ifdef PC_SEQ_BNE_EN
            n = 1'($urandom);
`endif
            run_instr(mk_word(8'($urandom)), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), n);
        end
    endtask

`ifdef PC_SEQ_BNE_EN
    task automatic test_bne();
        logic [31:0] start;
        start = m_pc;
        run_instr(mk_word(8'h04), 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (PC !== start + 32'd20) begin failures++; $display("FAIL bne_taken: got %h expected %h", PC, start + 32'd20); end
        start = m_pc;
        run_instr(mk_word(8'h04), 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        checks++; if (PC !== start + 32'd4) begin failures++; $display("FAIL bne_not_taken: got %h expected %h", PC, start + 32'd4); end
    endtask
`endif

    initial begin
        test_reset();
        test_straight_line();
        test_imem_wait();
        test_branch();
        test_priority();
        test_data_stall();
        test_reset_mid_stall();
        test_count_wrap();
`ifdef PC_SEQ_BNE_EN
        test_bne();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: CLK and RESET.
REQ-002 Ports SHALL be, clock and reset first:
- CLK  in  1  rising-edge clock
- RESET  in  1  async active-high reset
- INSTRUCTION  in  32  fetched word from instruction memory
- IMEM_BUSYWAIT  in  1  instruction memory busy
- DMEM_BUSYWAIT  in  1  data memory busy
- JUMP  in  1  decoded jump
- BRANCH  in  1  decoded beq
- ZERO  in  1  ALU zero flag
- IMEM_READ  out  1  fetch request
- PC  out  32  current program counter, also the fetch address
- INSTR_OUT  out  32  latched instruction to decode
- INSTR_VALID  out  1  execute cycle; gates reg_file WRITE
- STALL  out  1  waiting on data memory
- INSTR_COUNT  out  16  retired-instruction counter
REQ-003 The block SHALL have no parameters; widths SHALL come from the shared package.

Function
REQ-004 The FSM SHALL have states IDLE, FETCH, EXEC and MEM_STALL.
REQ-005 In IDLE, the block SHALL drive all request/valid outputs low and go to FETCH on the next edge.
REQ-006 In FETCH, the block SHALL drive IMEM_READ=1 with PC as the address.
- On an edge with IMEM_BUSYWAIT=0: latch INSTRUCTION into INSTR_OUT, go to EXEC.
- Otherwise: stay in FETCH, PC unchanged.
REQ-007 In EXEC, the block SHALL drive INSTR_VALID=1 for exactly one cycle and IMEM_READ=0.
REQ-008 In EXEC with DMEM_BUSYWAIT=1, the block SHALL go to MEM_STALL without updating PC.
REQ-009 In EXEC with DMEM_BUSYWAIT=0, the block SHALL load next-PC, increment INSTR_COUNT and go to FETCH.
REQ-010 In MEM_STALL, the block SHALL drive STALL=1 and INSTR_VALID=0.
- When DMEM_BUSYWAIT=0 at an edge: load next-PC, increment INSTR_COUNT, go to FETCH.
- JUMP/BRANCH/ZERO SHALL be sampled at that edge.
REQ-011 Next-PC SHALL be PC+4 when not taken.
- Taken: PC + 4 + (sign-extend(INSTR_OUT[23:16]) << 2).
- All arithmetic mod 2^32; wrap-around is permitted.
REQ-012 A jump or branch SHALL be taken when JUMP=1, or when BRANCH=1 and ZERO=1.
- JUMP SHALL win when JUMP and BRANCH are both asserted.
REQ-013 Minimum latency SHALL be 2 cycles per instruction (FETCH, EXEC) with zero-wait memories.
REQ-014 INSTR_COUNT SHALL wrap from 0xFFFF to 0x0000 without a flag.
REQ-015 IMEM_BUSYWAIT SHALL be ignored outside FETCH.
REQ-016 DMEM_BUSYWAIT SHALL be ignored outside EXEC and MEM_STALL.

Reset
REQ-017 RESET=1 SHALL immediately force the following, regardless of state (including mid-fetch or mid-stall):
- state IDLE
- PC=0, INSTR_OUT=0, INSTR_COUNT=0
- IMEM_READ=0, INSTR_VALID=0, STALL=0
REQ-018 After RESET deasserts, the first IMEM_READ SHALL appear one cycle after IDLE, with PC=0.

Configuration
REQ-019 Macro PC_SEQ_BNE_EN SHALL control bne support.
- Defined: add input BNE (1 bit). Taken condition also includes BNE=1 with ZERO=0. Priority: JUMP, then BRANCH, then BNE.
- Undefined: no BNE port, bne logic absent.

Structure
REQ-020 Package cpu_pkg SHALL hold:
- state enum: IDLE, FETCH, EXEC, MEM_STALL
- PC_WIDTH=32, INSTR_WIDTH=32, COUNT_WIDTH=16
- PC_STEP=4
- OFFSET field position [23:16]
REQ-021 The block SHALL contain one combinational sub-module, pc_target_adder (PC, offset, taken -> next-PC).
REQ-022 The sequential logic SHALL remain in pc_sequencer.

Verification
REQ-023 Reset and straight-line sequence: RESET pulse, zero-wait memories, 3 plain instructions -> PC 0, 4, 8, 12 on successive FETCHes; INSTR_COUNT=3.
REQ-024 IMEM wait: IMEM_BUSYWAIT=1 for 3 cycles in FETCH at PC=8 -> PC holds 8, IMEM_READ held high; EXEC follows one edge after busy drops.
REQ-025 Branches at PC=0x10:
- BRANCH=1, ZERO=1, offset 0xFE -> next PC 0x0C.
- Same with ZERO=0 -> next PC 0x14.
REQ-026 Priority: JUMP=1 and BRANCH=1, offset 0x02, PC=0x20 -> PC 0x2C.
REQ-027 Data stall: DMEM_BUSYWAIT=1 for 4 cycles in EXEC -> STALL=1 for 4 cycles, INSTR_VALID low during stall, PC updates once.
REQ-028 Corner cases:
- RESET asserted mid-MEM_STALL -> outputs zero asynchronously.
- INSTR_COUNT preset near 0xFFFF wraps to 0x0000.
- With PC_SEQ_BNE_EN: BNE=1, ZERO=0 -> taken.
